// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Op encodings are also consumed by the ALU control and hazard unit.
package muldiv_pkg;

    localparam int WIDTH_DEF = 32;

    localparam logic [1:0] OP_MULT  = 2'd0;
    localparam logic [1:0] OP_MULTU = 2'd1;
    localparam logic [1:0] OP_DIV   = 2'd2;
    localparam logic [1:0] OP_DIVU  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_e;

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negation, used for operand magnitudes
// and for the final sign correction of product, quotient and remainder.
module muldiv_signfix #(
    parameter int W = 32
) (
    input  logic [W-1:0] val_i,
    input  logic         neg_i,
    output logic [W-1:0] val_o
);

    assign val_o = neg_i ? ('0 - val_i) : val_i;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO.
// One shared 2*WIDTH accumulator serves shift-add and restoring divide.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] RSdata_i,
    input  logic [WIDTH-1:0] RTdata_i,
    input  logic             hi_we_i,
    input  logic             lo_we_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] HI_o,
    output logic [WIDTH-1:0] LO_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               is_div_q, is_div_d;
    logic               pneg_q, pneg_d;
    logic               qneg_q, qneg_d;
    logic               rneg_q, rneg_d;
    logic               done_q, done_d;

    logic               signed_op;
    logic               neg_a;
    logic               neg_b;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] div_next;

    assign signed_op = (op_i == OP_MULT) || (op_i == OP_DIV);
    assign neg_a     = signed_op & RSdata_i[WIDTH-1];
    assign neg_b     = signed_op & RTdata_i[WIDTH-1];

    muldiv_signfix #(.W(WIDTH)) u_abs_a (
        .val_i (RSdata_i),
        .neg_i (neg_a),
        .val_o (abs_a)
    );

    muldiv_signfix #(.W(WIDTH)) u_abs_b (
        .val_i (RTdata_i),
        .neg_i (neg_b),
        .val_o (abs_b)
    );

    muldiv_signfix #(.W(2*WIDTH)) u_fix_prod (
        .val_i (acc_q),
        .neg_i (pneg_q),
        .val_o (prod_fix)
    );

    muldiv_signfix #(.W(WIDTH)) u_fix_quo (
        .val_i (acc_q[WIDTH-1:0]),
        .neg_i (qneg_q),
        .val_o (quo_fix)
    );

    muldiv_signfix #(.W(WIDTH)) u_fix_rem (
        .val_i (acc_q[2*WIDTH-1:WIDTH]),
        .neg_i (rneg_q),
        .val_o (rem_fix)
    );

    // Multiply: multiplier sits in the low half and shifts out LSB first.
    // Divide: {remainder, quotient} shifts left, quotient bits enter at LSB.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                 + (acc_q[0] ? {1'b0, opb_q} : '0);
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};
        rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        diff     = rem_sh - {1'b0, opb_q};
        if (diff[WIDTH]) begin
            div_next = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
            div_next = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        is_div_d = is_div_q;
        pneg_d   = pneg_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        done_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d  = S_CALC;
                    cnt_d    = '0;
                    acc_d    = {{WIDTH{1'b0}}, abs_a};
                    opb_d    = abs_b;
                    is_div_d = op_i[1];
                    pneg_d   = neg_a ^ neg_b;
                    // A zero divisor must leave the all-ones quotient intact.
                    qneg_d   = (neg_a ^ neg_b) && (RTdata_i != '0);
                    rneg_d   = neg_a;
                end else begin
                    if (hi_we_i) hi_d = RSdata_i;
                    if (lo_we_i) lo_d = RSdata_i;
                end
            end
            S_CALC: begin
                acc_d = is_div_q ? div_next : mul_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) state_d = S_FIX;
            end
            S_FIX: begin
                if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            is_div_q <= 1'b0;
            pneg_q   <= 1'b0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            is_div_q <= is_div_d;
            pneg_q   <= pneg_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            done_q   <= done_d;
        end
    end

    assign busy_o = (state_q != S_IDLE);
    assign done_o = done_q;
    assign HI_o   = hi_q;
    assign LO_o   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and random checks of muldiv_unit against an arithmetic model.
// Inputs change and outputs are sampled on the falling edge.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] RSdata_i;
    logic [31:0] RTdata_i;
    logic        hi_we_i;
    logic        lo_we_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] HI_o;
    logic [31:0] LO_o;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] prev_hi;
    logic [31:0] prev_lo;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start_i  (start_i),
        .op_i     (op_i),
        .RSdata_i (RSdata_i),
        .RTdata_i (RTdata_i),
        .hi_we_i  (hi_we_i),
        .lo_we_i  (lo_we_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .HI_o     (HI_o),
        .LO_o     (LO_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Returns {HI, LO} computed directly from the architectural rules.
    function automatic logic [63:0] ref_model(input logic [1:0] op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa, sb;
        int     q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            OP_MULT:  return 64'(sa * sb);
            OP_MULTU: return {32'b0, a} * {32'b0, b};
            OP_DIV: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    return {32'h0, 32'h8000_0000};
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
                return {r, q};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    task automatic do_op(input string tag, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input bit perturb, input bit lo_at_start);
        logic [63:0] exp;
        int          n;
        bit          hold_ok;
        exp = ref_model(op, a, b);
        @(negedge clk_i);
        start_i  = 1'b1;
        op_i     = op;
        RSdata_i = a;
        RTdata_i = b;
        lo_we_i  = lo_at_start;
        @(negedge clk_i);
        start_i = 1'b0;
        lo_we_i = 1'b0;
        chk({tag, "_busy_start"}, 64'(busy_o), 64'd1);
        n       = 0;
        hold_ok = 1'b1;
        while (done_o !== 1'b1 && n < 40) begin
            if (HI_o !== prev_hi || LO_o !== prev_lo || busy_o !== 1'b1)
                hold_ok = 1'b0;
            if (perturb) begin
                RSdata_i = $urandom;
                RTdata_i = $urandom;
                start_i  = (n == 5);
                hi_we_i  = (n == 6);
            end
            @(negedge clk_i);
            n++;
        end
        start_i = 1'b0;
        hi_we_i = 1'b0;
        chk({tag, "_hold"}, 64'(hold_ok), 64'd1);
        chk({tag, "_latency"}, 64'(n), 64'd33);
        chk({tag, "_done"}, 64'(done_o), 64'd1);
        chk({tag, "_busy_end"}, 64'(busy_o), 64'd0);
        chk({tag, "_hi"}, 64'(HI_o), 64'(exp[63:32]));
        chk({tag, "_lo"}, 64'(LO_o), 64'(exp[31:0]));
        @(negedge clk_i);
        chk({tag, "_done_pulse"}, 64'(done_o), 64'd0);
        prev_hi = exp[63:32];
        prev_lo = exp[31:0];
    endtask

    initial begin
        int          n_done;
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        rst_i    = 1'b0;
        start_i  = 1'b0;
        op_i     = OP_MULT;
        RSdata_i = '0;
        RTdata_i = '0;
        hi_we_i  = 1'b0;
        lo_we_i  = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("rst_hi", 64'(HI_o), 64'd0);
        chk("rst_lo", 64'(LO_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        rst_i = 1'b1;

        RSdata_i = 32'h1234_5678;
        hi_we_i  = 1'b1;
        @(negedge clk_i);
        hi_we_i = 1'b0;
        chk("mthi_hi", 64'(HI_o), 64'h1234_5678);
        chk("mthi_lo", 64'(LO_o), 64'd0);

        RSdata_i = 32'hA5A5_0001;
        hi_we_i  = 1'b1;
        lo_we_i  = 1'b1;
        @(negedge clk_i);
        hi_we_i = 1'b0;
        lo_we_i = 1'b0;
        chk("mthilo_hi", 64'(HI_o), 64'hA5A5_0001);
        chk("mthilo_lo", 64'(LO_o), 64'hA5A5_0001);
        prev_hi = 32'hA5A5_0001;
        prev_lo = 32'hA5A5_0001;

        do_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0);
        do_op("mult_neg", OP_MULT, -32'sd3, 32'd7, 0, 0);
        do_op("div_neg", OP_DIV, -32'sd7, 32'd2, 1, 0);
        do_op("divu_lo_we", OP_DIVU, 32'd100, 32'd7, 0, 1);
        do_op("divu_zero", OP_DIVU, 32'd5, 32'd0, 0, 0);
        do_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        do_op("div_negzero", OP_DIV, -32'sd9, 32'd0, 0, 0);
        do_op("div_negdiv", OP_DIV, 32'd9, -32'sd4, 0, 0);

        @(negedge clk_i);
        start_i  = 1'b1;
        op_i     = OP_MULTU;
        RSdata_i = 32'd1000;
        RTdata_i = 32'd3000;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (9) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        chk("midrst_busy", 64'(busy_o), 64'd0);
        chk("midrst_hi", 64'(HI_o), 64'd0);
        chk("midrst_lo", 64'(LO_o), 64'd0);
        chk("midrst_done", 64'(done_o), 64'd0);
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            if (done_o === 1'b1 || busy_o === 1'b1) n_done++;
        end
        chk("midrst_quiet", 64'(n_done), 64'd0);
        prev_hi = '0;
        prev_lo = '0;
        do_op("midrst_reissue", OP_MULTU, 32'd1000, 32'd3000, 0, 0);

        for (int i = 0; i < 12; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            if (i % 4 == 1) rb = 32'($urandom_range(0, 15));
            if (i % 4 == 2) rb = -32'($urandom_range(1, 9));
            do_op("rand", rop, ra, rb, (i % 3 == 0), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
